// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM states (CHECK is reachable only with the checksum build)
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   WORD_W         : instruction word width
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   byte_in/byte_valid/byte_ready : valid/ready byte stream into the loader
//   we/waddr/wdata                : one write pulse per packed word
// Modports: slave = loader side, master = host/memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    import imem_loader_pkg::*;

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, we, waddr, wdata
    );

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes big-endian into one instruction word.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : drop the partial word and restart at byte 0
//   accept         : data_byte is consumed this cycle
//   data_byte      : incoming byte
//   word           : packed word (byte 0 in the MSB lane)
//   last_byte      : the next accepted byte completes the word
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        data_byte,
    output logic [WORD_W-1:0] word,
    output logic              last_byte
);

    logic [1:0] cnt;

    assign last_byte = (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            // Lane k sits at bits [31-8k -: 8], so the first byte lands in the MSB.
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (cnt == 2'(k)) word[WORD_W-1-8*k -: 8] <= data_byte;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams bytes into 32-bit big-endian words and writes them
// to instruction memory at word addresses 0,1,2,... while holding the core.
//   reloj, reset : clock, synchronous active-high reset
//   start        : begin a load (honoured only when idle or done)
//   word_count   : words to load, clamped to 2**ADDR_W
//   bus          : byte stream in, memory write port out (imem_loader_if.slave)
//   cpu_hold     : keeps the core parked while a load is in progress
//   busy, done   : load in progress / load finished (level)
//   err          : checksum mismatch
// Build option IMEM_LOADER_CHECKSUM_EN: after the last word, one extra byte
// is taken and err is set when it does not zero the mod-256 byte sum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_clamped;
    logic              accept, pk_clear, last_byte, start_load;

    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign bus.waddr     = ptr;
    assign cpu_hold      = busy;
    assign done          = (state == ST_DONE);

    imem_loader_byte_packer u_packer (
        .clk       (reloj),
        .rst       (reset),
        .clear     (pk_clear),
        .accept    (accept),
        .data_byte (bus.byte_in),
        .word      (bus.wdata),
        .last_byte (last_byte)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic       check_take;
    logic [7:0] sum;
    logic [7:0] total;
    logic       err_q;

    assign total = sum + bus.byte_in;
    assign err   = err_q;
`endif

    always_ff @(posedge reloj) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        pk_clear       = 1'b0;
        start_load     = 1'b0;
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        busy           = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_take     = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // A zero-length load finishes at once and writes nothing.
                    if (count_clamped == '0) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx   = ST_RECV;
                        start_load = 1'b1;
                        pk_clear   = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                accept         = bus.byte_valid;
                if (bus.byte_valid && last_byte) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                bus.we   = 1'b1;
                busy     = 1'b1;
                pk_clear = 1'b1;
                if (remaining == (ADDR_W+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = ST_CHECK;
`else
                    state_nx = ST_DONE;
`endif
                end else begin
                    state_nx = ST_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) begin
                    check_take = 1'b1;
                    state_nx   = ST_DONE;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (start_load) begin
            ptr       <= '0;
            remaining <= count_clamped;
        end else if (bus.we) begin
            // A full 2**ADDR_W load wraps ptr to 0 only after its final write.
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge reloj) begin
        if (reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (start_load) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            sum <= total;
        end else if (check_take) begin
            err_q <= (total != 8'd0);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader with a word-level reference model.
module tb_imem_loader;

    localparam int AW   = 3;
    localparam int MAXW = 1 << AW;

    logic          reloj = 1'b0;
    logic          reset, start;
    logic [AW:0]   word_count;
    logic          cpu_hold, busy, done, err;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .reloj      (reloj),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 reloj = ~reloj;

    int checks = 0;
    int errors = 0;

    // Reference model: load progress expressed as words left / bytes in word.
    bit          m_active, m_write, m_inchk, m_done, m_err;
    int          m_left, m_ptr, m_cnt;
    logic [7:0]  m_sum;
    logic [31:0] m_word;

    int          log_addr[$];
    logic [31:0] log_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input int wc, input bit bv, input int b);
        logic [7:0] bb;
        logic [7:0] t;
        int n;
        bb = 8'(b);
        if (r) begin
            m_active = 0; m_write = 0; m_inchk = 0; m_done = 0; m_err = 0;
            m_ptr = 0; m_cnt = 0;
        end else if (m_write) begin
            m_write = 0;
            m_ptr++;
            m_left--;
            m_cnt = 0;
            if (m_left == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                m_inchk = 1;
`else
                m_active = 0;
                m_done   = 1;
`endif
            end
        end else if (m_inchk) begin
            if (bv) begin
                t = m_sum + bb;
                m_err   = (t != 8'd0);
                m_inchk = 0;
                m_active = 0;
                m_done  = 1;
            end
        end else if (m_active) begin
            if (bv) begin
                m_word = {m_word[23:0], bb};
                m_sum  = m_sum + bb;
                m_cnt++;
                if (m_cnt == 4) m_write = 1;
            end
        end else if (s) begin
            n = (wc > MAXW) ? MAXW : wc;
            if (n == 0) begin
                m_done = 1;
            end else begin
                m_active = 1; m_left = n; m_ptr = 0; m_done = 0; m_err = 0;
                m_sum = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy",       32'(busy),           32'(m_active));
        chk("cpu_hold",   32'(cpu_hold),       32'(m_active));
        chk("byte_ready", 32'(bus.byte_ready), 32'(m_active && !m_write));
        chk("we",         32'(bus.we),         32'(m_write));
        chk("done",       32'(done),           32'(m_done));
        chk("err",        32'(err),            32'(m_err));
        if (m_write) begin
            chk("waddr", 32'(bus.waddr), 32'(m_ptr));
            chk("wdata", bus.wdata,      m_word);
        end
        if (bus.we === 1'b1) begin
            log_addr.push_back(int'(bus.waddr));
            log_data.push_back(bus.wdata);
        end
    endtask

    // Drive one cycle's inputs, advance the model, then check at the falling edge.
    task automatic cycle(input bit r, input bit s, input int wc, input bit bv, input int b);
        reset          = r;
        start          = s;
        word_count     = (AW+1)'(wc);
        bus.byte_valid = bv;
        bus.byte_in    = 8'(b);
        model_step(r, s, wc, bv, b);
        @(negedge reloj);
        check_outputs();
    endtask

    // mode: 0 full rate, 1 toggling valid, 2 random gaps.
    // abort_at: reset after that many accepted bytes (-1: never).
    // poke: pulse start while receiving.
    task automatic run_load(input int wc, input logic [7:0] q_in[$], input int mode,
                            input int abort_at, input bit poke);
        logic [7:0] q[$];
        int acc, cyc;
        bit bv, s, poked, take;
        q = q_in;
        acc = 0; cyc = 0; poked = 0;
        cycle(0, 1, wc, 0, 0);
        while (m_active) begin
            if (cyc >= 400) begin
                chk("load_timeout", 32'(m_active), 32'd0);
                break;
            end
            if (abort_at >= 0 && acc == abort_at) begin
                cycle(1, 0, 0, 0, 0);
                break;
            end
            case (mode)
                0:       bv = 1'b1;
                1:       bv = (cyc % 2) == 0;
                default: bv = ($urandom_range(0, 3) != 0);
            endcase
            bv = bv && (q.size() > 0);
            s  = poke && !poked && acc == 2;
            if (s) poked = 1;
            take = bv && m_active && !m_write;
            cycle(0, s, 1, bv, bv ? int'(q[0]) : int'($urandom_range(0, 255)));
            if (take) begin
                void'(q.pop_front());
                acc++;
            end
            cyc++;
        end
        cycle(0, 0, 0, 0, 0);
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] q[$]);
        logic [7:0] t;
        t = 8'd0;
        foreach (q[i]) t = t + q[i];
        return 8'(9'h100 - {1'b0, t});
    endfunction

    initial begin
        logic [7:0] q[$];
        int n, nw, md, ab;

        reset = 1; start = 0; word_count = '0;
        bus.byte_valid = 0; bus.byte_in = '0;
        @(negedge reloj);

        // Reset state and idle behaviour.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'hAA);
        chk("idle_no_we", 32'(log_addr.size()), 32'd0);

        // Two-word load, full rate then toggling valid.
        for (int pass = 0; pass < 2; pass++) begin
            log_addr.delete(); log_data.delete();
            q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
            q.push_back(8'hB4);
`endif
            run_load(2, q, pass, -1, 0);
            chk("two_nwr", 32'(log_addr.size()), 32'd2);
            if (log_addr.size() == 2) begin
                chk("two_a0", 32'(log_addr[0]), 32'd0);
                chk("two_d0", log_data[0], 32'h12345678);
                chk("two_a1", 32'(log_addr[1]), 32'd1);
                chk("two_d1", log_data[1], 32'hDEADBEEF);
            end
            chk("two_done", 32'(done), 32'd1);
            chk("two_hold", 32'(cpu_hold), 32'd0);
            chk("two_err", 32'(err), 32'd0);
        end

        // Zero-length load from a fresh reset.
        log_addr.delete(); log_data.delete();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("zero_nwr", 32'(log_addr.size()), 32'd0);

        // start pulse mid-receive is ignored.
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom_range(0, 255)));
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(csum_of(q));
`endif
        run_load(3, q, 0, -1, 1);
        chk("poke_nwr", 32'(log_addr.size()), 32'd3);

        // Reset after two bytes of word 1, then a fresh one-word load.
        log_addr.delete(); log_data.delete();
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(2, q, 0, 6, 0);
        chk("abort_nwr", 32'(log_addr.size()), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        log_addr.delete(); log_data.delete();
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(8'hF6);
`endif
        run_load(1, q, 0, -1, 0);
        chk("after_nwr", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("after_a0", 32'(log_addr[0]), 32'd0);
            chk("after_d0", log_data[0], 32'h01020304);
        end
        chk("after_err", 32'(err), 32'd0);
        chk("after_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        run_load(1, q, 0, -1, 0);
        chk("csum_bad_err", 32'(err), 32'd1);
        chk("csum_bad_done", 32'(done), 32'd1);
`endif

        // Clamp: 15 words requested on an 8-deep memory.
        log_addr.delete(); log_data.delete();
        q.delete();
        for (int i = 0; i < 4 * MAXW + 1; i++) q.push_back(8'($urandom_range(0, 255)));
        run_load(15, q, 2, -1, 0);
        chk("clamp_nwr", 32'(log_addr.size()), 32'(MAXW));

        // Random loads, gaps and occasional aborts.
        for (int t = 0; t < 14; t++) begin
            n  = $urandom_range(0, 15);
            nw = (n > MAXW) ? MAXW : n;
            md = $urandom_range(0, 2);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4 * nw) : -1;
            q.delete();
            for (int i = 0; i < 4 * nw; i++) q.push_back(8'($urandom_range(0, 255)));
            q.push_back(($urandom_range(0, 1) == 0) ? csum_of(q) : 8'($urandom_range(0, 255)));
            run_load(n, q, md, ab, $urandom_range(0, 1) == 1);
        end

        repeat (3) cycle(0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that fills the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit big-endian instruction word. It issues one write per word at incrementing word addresses. While loading, it asserts cpu_hold so the core stays parked at PC 0 and does not fetch partially written code.

Parameters:
ADDR_W, 8, word-address width of the instruction memory (depth 2**ADDR_W words)

Ports:
reloj  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  single-cycle request to begin a load; sampled only in IDLE/DONE
word_count  input  ADDR_W+1  number of words to load, sampled on accepted start; values above 2**ADDR_W clamp to 2**ADDR_W
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept a byte this cycle
we  output  1  instruction-memory write enable, one-cycle pulse per word
waddr  output  ADDR_W  word address of the write
wdata  output  32  packed instruction word
cpu_hold  output  1  high while a load is in progress (drives the core's reset/stall)
busy  output  1  FSM not in IDLE/DONE
done  output  1  level, high in DONE until the next accepted start or reset
err  output  1  checksum mismatch flag; constant 0 when IMEM_LOADER_CHECKSUM_EN is undefined

Behaviour:
- Reset values: state IDLE; byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, busy=0, done=0, err=0; byte counter=0; word pointer=0.
- States: IDLE, RECV, WRITE, CHECK (only with feature), DONE.
- IDLE/DONE + start: latch clamped word_count into remaining. If the count is 0, go to DONE and keep done=1, with no writes. Otherwise clear the word pointer, byte counter, done and err, then go to RECV. start in any other state is ignored.
- RECV: byte_ready=1. A byte is accepted when byte_valid&&byte_ready.
  - Byte k (k=0..3) goes to wdata[31-8k -: 8]. The first byte is the MSB.
  - The 4th accepted byte moves the FSM to WRITE on the next edge.
  - Gaps in byte_valid stall the FSM with no state change.
- WRITE: byte_ready=0; we=1 for exactly this cycle; waddr=word pointer; wdata holds the packed word.
  - Next edge: the word pointer increments and the byte counter clears.
  - If this was the last word: go to DONE, or to CHECK when the feature is enabled. Otherwise go to RECV.
- Throughput: 4 bytes per 5 cycles at full rate. The write happens 1 cycle after the 4th byte is accepted.
- cpu_hold=busy=1 in RECV, WRITE and CHECK. Both drop on the edge that enters DONE.
- Word pointer wrap: at most 2**ADDR_W words are written because of the clamp, so waddr never wraps within one load.
- Reset mid-operation returns the FSM to IDLE on the next edge and discards any partial word. No write is issued for a partial word. The next load starts at address 0.
- byte_valid while byte_ready=0: the byte is not consumed, and the source must hold it.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - An 8-bit running sum (modulo 256) is kept of all data bytes accepted in the load.
  - After the last WRITE, the FSM enters CHECK with byte_ready=1 and accepts one extra byte.
  - err is set if sum+byte != 0 mod 256.
  - The FSM then goes to DONE. err holds until the next accepted start or reset.
- Undefined: CHECK state is absent, err=0, and the FSM goes WRITE->DONE directly.

Decomposition:
Shared package:
- state encoding constants (IDLE, RECV, WRITE, CHECK, DONE)
- BYTES_PER_WORD=4
- WORD_W=32
Sub-module byte_packer:
- 2-bit byte counter plus a 32-bit shift/lane register
- inputs: clear, accept, byte
- outputs: word, last_byte
The top level holds the FSM, word pointer, remaining count and the checksum.

Test Plan:
- Reset then idle -> all outputs 0; byte_valid=1 gives byte_ready=0 and no writes.
- word_count=2, bytes 12 34 56 78 DE AD BE EF at full rate -> we at waddr0 with wdata 0x12345678, then waddr1 with 0xDEADBEEF; done=1 and cpu_hold=0 afterwards; exactly 2 we pulses.
- Same load with byte_valid toggling every other cycle -> identical writes; byte_ready=0 only in WRITE cycles.
- start with word_count=0 -> done=1 next cycle, no we, cpu_hold stays 0; a start pulse during RECV -> ignored, pointer unchanged.
- Reset after 2 bytes of word 1 -> IDLE, no we. A new load of 1 word with 01 02 03 04 -> waddr0, wdata 0x01020304.
- With IMEM_LOADER_CHECKSUM_EN, word_count=1 with bytes 01 02 03 04:
  - checksum byte F6 -> err=0
  - checksum byte F5 -> err=1
  - done=1 in both cases.
